// File: rtl/rob_retire_unit.sv
// Commit stage behind the ROB head: in-order single retire, mispredict flush/redirect, recovery hold.
// Optional RETIRE_PERF_CNT_EN adds retire/flush performance counters.
module rob_retire_unit #(
  parameter int REG_WIDTH    = 32,
  parameter int PC_WIDTH     = 32,
  parameter int ARF_ID_WIDTH = 5,
  parameter int ROB_ID_WIDTH = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    head_valid,
  input  logic [ROB_ID_WIDTH-1:0] head_rob_id,
  input  logic                    head_dst_valid,
  input  logic [ARF_ID_WIDTH-1:0] head_dst_arf_id,
  input  logic                    head_reg_ready,
  input  logic [REG_WIDTH-1:0]    head_reg_data,
  input  logic                    head_br_mispredict,
  input  logic                    head_ld_mispredict,
  input  logic [PC_WIDTH-1:0]     head_pc,
  input  logic [PC_WIDTH-1:0]     head_br_target,
  output logic                    rob_deq_ready,
  output logic                    arf_wr_en,
  output logic [ARF_ID_WIDTH-1:0] arf_wr_id,
  output logic [REG_WIDTH-1:0]    arf_wr_data,
  output logic                    rat_clr_en,
  output logic [ROB_ID_WIDTH-1:0] rat_clr_rob_id,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [PC_WIDTH-1:0]     redirect_pc,
  output logic                    busy_recover
`ifdef RETIRE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_retired,
  output logic [31:0]             perf_flushes
`endif
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               commit;
  logic               run_active;

  assign commit     = head_valid & head_reg_ready;
  assign run_active = rst_aL & (state == RUN);

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rob_deq_ready  = 1'b0;
    arf_wr_en      = 1'b0;
    arf_wr_id      = '0;
    arf_wr_data    = '0;
    rat_clr_en     = 1'b0;
    rat_clr_rob_id = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy_recover   = 1'b0;

    if (run_active && commit) begin
      if (head_ld_mispredict) begin
        // The load itself is replayed, so it stays in the ROB and writes nothing.
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = head_pc;
        state_next     = RECOVER;
        cnt_next       = CNT_W'(FLUSH_CYCLES - 1);
      end else begin
        rob_deq_ready  = 1'b1;
        arf_wr_en      = head_dst_valid & (head_dst_arf_id != '0);
        rat_clr_en     = head_dst_valid & (head_dst_arf_id != '0);
        arf_wr_id      = head_dst_arf_id;
        arf_wr_data    = head_reg_data;
        rat_clr_rob_id = head_rob_id;
        if (head_br_mispredict) begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = head_br_target;
          state_next     = RECOVER;
          cnt_next       = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
    end

    if (state == RECOVER) begin
      busy_recover = rst_aL;
      if (cnt == '0) state_next = RUN;
      else           cnt_next   = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

`ifdef RETIRE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      perf_retired <= '0;
      perf_flushes <= '0;
    end else begin
      if (rob_deq_ready) perf_retired <= perf_retired + 32'd1;
      if (flush)         perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed self-checking bench for rob_retire_unit; inputs change on negedge, outputs sampled 1ns later.
module tb_rob_retire_unit;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        head_valid;
  logic [2:0]  head_rob_id;
  logic        head_dst_valid;
  logic [4:0]  head_dst_arf_id;
  logic        head_reg_ready;
  logic [31:0] head_reg_data;
  logic        head_br_mispredict;
  logic        head_ld_mispredict;
  logic [31:0] head_pc;
  logic [31:0] head_br_target;
  logic        rob_deq_ready;
  logic        arf_wr_en;
  logic [4:0]  arf_wr_id;
  logic [31:0] arf_wr_data;
  logic        rat_clr_en;
  logic [2:0]  rat_clr_rob_id;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy_recover;
`ifdef RETIRE_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_flushes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rob_retire_unit #(
    .REG_WIDTH(32), .PC_WIDTH(32), .ARF_ID_WIDTH(5), .ROB_ID_WIDTH(3), .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk), .rst_aL(rst_aL),
    .head_valid(head_valid), .head_rob_id(head_rob_id),
    .head_dst_valid(head_dst_valid), .head_dst_arf_id(head_dst_arf_id),
    .head_reg_ready(head_reg_ready), .head_reg_data(head_reg_data),
    .head_br_mispredict(head_br_mispredict), .head_ld_mispredict(head_ld_mispredict),
    .head_pc(head_pc), .head_br_target(head_br_target),
    .rob_deq_ready(rob_deq_ready), .arf_wr_en(arf_wr_en), .arf_wr_id(arf_wr_id),
    .arf_wr_data(arf_wr_data), .rat_clr_en(rat_clr_en), .rat_clr_rob_id(rat_clr_rob_id),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy_recover(busy_recover)
`ifdef RETIRE_PERF_CNT_EN
    , .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_aL = 1'b0;
    head_valid = 1'b1; head_rob_id = 3'd0; head_dst_valid = 1'b1; head_dst_arf_id = 5'd5;
    head_reg_ready = 1'b1; head_reg_data = 32'h1234; head_br_mispredict = 1'b0;
    head_ld_mispredict = 1'b0; head_pc = '0; head_br_target = '0;

    // 1: reset with a ready head present
    for (int i = 0; i < 2; i++) begin
      next_cycle(); settle();
      chk("rst_deq", rob_deq_ready, 0);
      chk("rst_wr", arf_wr_en, 0);
      chk("rst_rat", rat_clr_en, 0);
      chk("rst_flush", flush, 0);
      chk("rst_redir", redirect_valid, 0);
      chk("rst_busy", busy_recover, 0);
    end
    next_cycle(); rst_aL = 1'b1; head_valid = 1'b0; settle();
    chk("post_rst_busy", busy_recover, 0);
    chk("post_rst_deq", rob_deq_ready, 0);

    // 2: normal retire, then x0 destination
    next_cycle();
    head_valid = 1'b1; head_reg_ready = 1'b1; head_dst_valid = 1'b1; head_dst_arf_id = 5'd5;
    head_reg_data = 32'hDEADBEEF; head_rob_id = 3'd3; settle();
    chk("ret_deq", rob_deq_ready, 1);
    chk("ret_wr", arf_wr_en, 1);
    chk("ret_id", arf_wr_id, 5);
    chk("ret_data", arf_wr_data, 32'hDEADBEEF);
    chk("ret_rat", rat_clr_en, 1);
    chk("ret_rat_id", rat_clr_rob_id, 3);
    chk("ret_flush", flush, 0);
    next_cycle(); head_dst_arf_id = 5'd0; head_rob_id = 3'd4; settle();
    chk("x0_deq", rob_deq_ready, 1);
    chk("x0_wr", arf_wr_en, 0);
    chk("x0_rat", rat_clr_en, 0);

    // 3: head not ready for three cycles
    for (int i = 0; i < 3; i++) begin
      next_cycle(); head_reg_ready = 1'b0; head_dst_arf_id = 5'd7; settle();
      chk("nr_deq", rob_deq_ready, 0);
      chk("nr_wr", arf_wr_en, 0);
    end
    next_cycle(); head_reg_ready = 1'b1; settle();
    chk("nr_done_deq", rob_deq_ready, 1);
    chk("nr_done_wr", arf_wr_en, 1);
    chk("nr_done_id", arf_wr_id, 7);

    // 4: branch mispredict commits and redirects to target
    next_cycle();
    head_br_mispredict = 1'b1; head_dst_arf_id = 5'd1; head_br_target = 32'h100; head_pc = 32'h80;
    settle();
    chk("br_deq", rob_deq_ready, 1);
    chk("br_wr", arf_wr_en, 1);
    chk("br_id", arf_wr_id, 1);
    chk("br_flush", flush, 1);
    chk("br_redir", redirect_valid, 1);
    chk("br_pc", redirect_pc, 32'h100);
    chk("br_busy", busy_recover, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); head_br_mispredict = 1'b0; settle();
      chk("br_rec_busy", busy_recover, 1);
      chk("br_rec_deq", rob_deq_ready, 0);
      chk("br_rec_flush", flush, 0);
      chk("br_rec_redir", redirect_valid, 0);
    end
    next_cycle(); settle();
    chk("br_run_busy", busy_recover, 0);
    chk("br_run_deq", rob_deq_ready, 1);

    // 5: load mispredict wins over branch mispredict, nothing committed
    next_cycle();
    head_ld_mispredict = 1'b1; head_br_mispredict = 1'b1; head_pc = 32'h40; head_br_target = 32'h200;
    settle();
    chk("ld_deq", rob_deq_ready, 0);
    chk("ld_wr", arf_wr_en, 0);
    chk("ld_rat", rat_clr_en, 0);
    chk("ld_flush", flush, 1);
    chk("ld_redir", redirect_valid, 1);
    chk("ld_pc", redirect_pc, 32'h40);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); head_ld_mispredict = 1'b0; head_br_mispredict = 1'b0; settle();
      chk("ld_rec_busy", busy_recover, 1);
      chk("ld_rec_deq", rob_deq_ready, 0);
    end
    next_cycle(); settle();
    chk("ld_run_busy", busy_recover, 0);

    // 6: reset during RECOVER, then ten back-to-back retires
    next_cycle(); head_br_mispredict = 1'b1; settle();
    chk("r6_flush", flush, 1);
    next_cycle(); head_br_mispredict = 1'b0; settle();
    chk("r6_busy", busy_recover, 1);
    next_cycle(); rst_aL = 1'b0; settle();
    chk("r6_rst_deq", rob_deq_ready, 0);
    chk("r6_rst_flush", flush, 0);
    next_cycle(); rst_aL = 1'b1; settle();
    chk("r6_run_busy", busy_recover, 0);
    for (int i = 0; i < 10; i++) begin
      chk("b2b_deq", rob_deq_ready, 1);
      chk("b2b_flush", flush, 0);
      next_cycle(); settle();
      if (i == 9) head_valid = 1'b0;
    end
`ifdef RETIRE_PERF_CNT_EN
    settle();
    chk("perf_retired", perf_retired, 10);
    chk("perf_flushes", perf_flushes, 0);
`endif
    head_valid = 1'b0;
    next_cycle(); settle();
    chk("idle_deq", rob_deq_ready, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
